// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the control unit and seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results and div_by_zero are held until the next operation completes.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]    step_cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic             r_ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Partial remainder stays below the divisor, so the shifted value is below
  // twice the divisor and the top bit of the difference is exactly the borrow.
  always_comb begin
    r_shift = {work_r, work_q[WIDTH-1]};
    r_diff  = r_shift - {1'b0, divisor_q};
    r_ge    = ~r_diff[WIDTH];
    r_next  = r_ge ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next  = {work_q[WIDTH-2:0], r_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      work_q          <= '0;
      work_r          <= '0;
      divisor_q       <= '0;
      step_cnt        <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE for back-to-back use.
        IDLE, DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
          if (bus.start) begin
            if (bus.divisor != '0) begin
              state     <= BUSY;
              bus.busy  <= 1'b1;
              work_q    <= bus.dividend;
              work_r    <= '0;
              divisor_q <= bus.divisor;
              step_cnt  <= '0;
            end else begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
            end
          end
        end
        BUSY: begin
          work_q   <= q_next;
          work_r   <= r_next;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == CW'(WIDTH - 1)) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_next;
            bus.remainder   <= r_next;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule
